clock_enable_divider: RTL and testbench

//  Parametrised, runtime-programmable clock-enable generator that supersedes the fixed toggle-flop dividers.

---
 rtl/clock_enable_divider.sv | 110 +++++++++++
 tb/tb_clock_enable_divider.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/clock_enable_divider.sv
// clock_enable_divider
//   Runtime-programmable clock-enable generator. Each of NUM_CH channels
//   produces a one-cycle tick every Ne cycles and a 50% square wave of
//   period 2*Ne, all in the clk_in domain (no derived clocks).
// Ports
//   clk_in   : system clock, rising edge
//   rst      : synchronous reset, active-high
//   ch_en    : per-channel run enable
//   cfg_wr   : one-cycle write strobe for a new divide ratio
//   cfg_sel  : channel index for cfg_wr (out-of-range writes are discarded)
//   cfg_div  : new divide ratio (0 behaves as 1)
//   resync   : restart all channels in phase
//   cfg_ack  : registered acknowledge, one cycle after every cfg_wr
//   tick     : registered one-cycle enable per channel
//   sq       : registered square wave per channel
module clock_enable_divider #(
    parameter int unsigned NUM_CH    = 3,
    parameter int unsigned DIV_W     = 16,
    parameter int unsigned RESET_DIV = 2,
    localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_sel,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              resync,
    output logic              cfg_ack,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq
);

    logic r_cfg_ack;

    // Every write is acknowledged, including discarded out-of-range ones
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_cfg_ack <= 1'b0;
        end else begin
            r_cfg_ack <= cfg_wr;
        end
    end

    assign cfg_ack = r_cfg_ack;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DIV_W-1:0] r_cnt;
        logic [DIV_W-1:0] r_div;
        logic [DIV_W-1:0] r_pend_div;
        logic             r_pend_vld;
        logic             r_tick;
        logic             r_sq;

        logic [DIV_W-1:0] w_ne_m1;
        logic             w_wrap;
        logic             w_hit;
        logic             w_apply;

        // Terminal count Ne-1, with a ratio of 0 treated as 1
        assign w_ne_m1 = (r_div == '0) ? '0 : r_div - DIV_W'(1);
        assign w_wrap  = ch_en[i] && (r_cnt == w_ne_m1);
        assign w_hit   = cfg_wr && (cfg_sel == CH_W'(i));
        // Pending ratio is only adopted when the counter restarts from 0
        assign w_apply = r_pend_vld && (resync || !ch_en[i] || w_wrap);

        always_ff @(posedge clk_in) begin
            if (rst) begin
                r_cnt      <= '0;
                r_div      <= DIV_W'(RESET_DIV);
                r_pend_div <= '0;
                r_pend_vld <= 1'b0;
                r_tick     <= 1'b0;
                r_sq       <= 1'b0;
            end else begin
                if (resync) begin
                    r_cnt  <= '0;
                    r_tick <= 1'b0;
                    r_sq   <= 1'b0;
                end else if (!ch_en[i]) begin
                    r_cnt  <= '0;
                    r_tick <= 1'b0;
                end else if (w_wrap) begin
                    r_cnt  <= '0;
                    r_tick <= 1'b1;
                    r_sq   <= ~r_sq;
                end else begin
                    r_cnt  <= r_cnt + DIV_W'(1);
                    r_tick <= 1'b0;
                end

                if (w_apply) begin
                    r_div      <= r_pend_div;
                    r_pend_vld <= 1'b0;
                end

                // A new write lands after any apply this cycle, so it waits
                // for the next restart point
                if (w_hit) begin
                    r_pend_div <= cfg_div;
                    r_pend_vld <= 1'b1;
                end
            end
        end

        assign tick[i] = r_tick;
        assign sq[i]   = r_sq;
    end

endmodule

// File: tb/tb_clock_enable_divider.sv
// tb_clock_enable_divider
//   Directed bench for clock_enable_divider (NUM_CH=3, DIV_W=16, RESET_DIV=2).
//   Outputs are sampled 1 time unit after each rising edge; inputs are
//   changed at the same point so they are stable for the next edge.
module tb_clock_enable_divider;

    logic        clk_in;
    logic        rst;
    logic [2:0]  ch_en;
    logic        cfg_wr;
    logic [1:0]  cfg_sel;
    logic [15:0] cfg_div;
    logic        resync;
    logic        cfg_ack;
    logic [2:0]  tick;
    logic [2:0]  sq;

    int n_vec;
    int n_err;

    clock_enable_divider #(
        .NUM_CH    (3),
        .DIV_W     (16),
        .RESET_DIV (2)
    ) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .ch_en   (ch_en),
        .cfg_wr  (cfg_wr),
        .cfg_sel (cfg_sel),
        .cfg_div (cfg_div),
        .resync  (resync),
        .cfg_ack (cfg_ack),
        .tick    (tick),
        .sq      (sq)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Expected tick/sq after edges 5..16 of the ratio-change scenario
    logic [2:0] t2_tick [12] = '{3'b000, 3'b111, 3'b000, 3'b101, 3'b000, 3'b101,
                                 3'b010, 3'b101, 3'b000, 3'b101, 3'b000, 3'b111};
    logic [2:0] t2_sq   [12] = '{3'b000, 3'b111, 3'b111, 3'b010, 3'b010, 3'b111,
                                 3'b101, 3'b000, 3'b000, 3'b101, 3'b101, 3'b010};
    // Expected tick/sq after edges 17..21 (out-of-range write issued before 17)
    logic [2:0] t5_tick [5] = '{3'b000, 3'b101, 3'b000, 3'b101, 3'b010};
    logic [2:0] t5_sq   [5] = '{3'b010, 3'b111, 3'b111, 3'b010, 3'b000};
    // Expected tick/sq over the first 6 edges after resync (ch0 ratio 3, ch2 ratio 6)
    logic [2:0] t4_tick [6] = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b101};
    logic [2:0] t4_sq   [6] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b001, 3'b100};

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst     = 1'b1;
        ch_en   = 3'b000;
        cfg_wr  = 1'b0;
        cfg_sel = 2'd0;
        cfg_div = 16'd0;
        resync  = 1'b0;

        // Reset state
        step();
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_sq",   32'(sq),   32'h0);
        chk("rst_ack",  32'(cfg_ack), 32'h0);

        // Default ratio 2 on all channels
        rst   = 1'b0;
        ch_en = 3'b111;
        step(); chk("t1_tick_e1", 32'(tick), 32'h0); chk("t1_sq_e1", 32'(sq), 32'h0);
        step(); chk("t1_tick_e2", 32'(tick), 32'h7); chk("t1_sq_e2", 32'(sq), 32'h7);
        step(); chk("t1_tick_e3", 32'(tick), 32'h0); chk("t1_sq_e3", 32'(sq), 32'h7);
        step(); chk("t1_tick_e4", 32'(tick), 32'h7); chk("t1_sq_e4", 32'(sq), 32'h0);

        // Ratio 5 to ch1 written with its count at 0; current period completes at 2
        cfg_wr  = 1'b1;
        cfg_sel = 2'd1;
        cfg_div = 16'd5;
        for (int k = 0; k < 12; k++) begin
            step();
            if (k == 0) begin
                chk("t2_ack", 32'(cfg_ack), 32'h1);
                cfg_wr = 1'b0;
            end else if (k == 1) begin
                chk("t2_ack_drop", 32'(cfg_ack), 32'h0);
            end
            chk($sformatf("t2_tick_e%0d", k + 5), 32'(tick), 32'(t2_tick[k]));
            chk($sformatf("t2_sq_e%0d",   k + 5), 32'(sq),   32'(t2_sq[k]));
        end

        // Out-of-range channel: acked, nothing changes period
        cfg_wr  = 1'b1;
        cfg_sel = 2'd3;
        cfg_div = 16'd9;
        for (int k = 0; k < 5; k++) begin
            step();
            if (k == 0) begin
                chk("t5_ack", 32'(cfg_ack), 32'h1);
                cfg_wr = 1'b0;
            end
            chk($sformatf("t5_tick_e%0d", k + 17), 32'(tick), 32'(t5_tick[k]));
            chk($sformatf("t5_sq_e%0d",   k + 17), 32'(sq),   32'(t5_sq[k]));
        end

        // Ratio 0 on ch0 applied while disabled, then ratio 1 while running
        ch_en   = 3'b000;
        cfg_wr  = 1'b1;
        cfg_sel = 2'd0;
        cfg_div = 16'd0;
        step();
        chk("t3_ack0", 32'(cfg_ack), 32'h1);
        chk("t3_off_tick", 32'(tick), 32'h0);
        chk("t3_off_sq", 32'(sq), 32'h0);
        cfg_wr = 1'b0;
        step();
        ch_en = 3'b001;
        step(); chk("t3_tick_r1", 32'(tick), 32'h1); chk("t3_sq_r1", 32'(sq[0]), 32'h1);
        step(); chk("t3_tick_r2", 32'(tick), 32'h1); chk("t3_sq_r2", 32'(sq[0]), 32'h0);
        cfg_wr  = 1'b1;
        cfg_div = 16'd1;
        step(); chk("t3_tick_r3", 32'(tick), 32'h1); chk("t3_sq_r3", 32'(sq[0]), 32'h1);
        chk("t3_ack1", 32'(cfg_ack), 32'h1);
        cfg_wr = 1'b0;
        step(); chk("t3_tick_r4", 32'(tick), 32'h1); chk("t3_sq_r4", 32'(sq[0]), 32'h0);
        step(); chk("t3_tick_r5", 32'(tick), 32'h1); chk("t3_sq_r5", 32'(sq[0]), 32'h1);

        // ch0 ratio 3, ch2 ratio 6, run out of phase, then resync
        ch_en   = 3'b000;
        cfg_wr  = 1'b1;
        cfg_sel = 2'd0;
        cfg_div = 16'd3;
        step();
        cfg_sel = 2'd2;
        cfg_div = 16'd6;
        step();
        cfg_wr = 1'b0;
        step();
        ch_en = 3'b101;
        for (int k = 0; k < 4; k++) step();
        resync = 1'b1;
        step();
        chk("t4_rs_tick", 32'(tick), 32'h0);
        chk("t4_rs_sq",   32'(sq),   32'h0);
        resync = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("t4_tick_r%0d", k + 1), 32'(tick), 32'(t4_tick[k]));
            chk($sformatf("t4_sq_r%0d",   k + 1), 32'(sq),   32'(t4_sq[k]));
        end

        // Reset mid-period with a coincident write: write lost, ratios back to 2
        step();
        rst     = 1'b1;
        cfg_wr  = 1'b1;
        cfg_sel = 2'd0;
        cfg_div = 16'd9;
        step();
        chk("t6_tick", 32'(tick), 32'h0);
        chk("t6_sq",   32'(sq),   32'h0);
        chk("t6_ack",  32'(cfg_ack), 32'h0);
        rst    = 1'b0;
        cfg_wr = 1'b0;
        ch_en  = 3'b111;
        step(); chk("t6_ack_after", 32'(cfg_ack), 32'h0); chk("t6_tick_e1", 32'(tick), 32'h0);
        step(); chk("t6_tick_e2", 32'(tick), 32'h7); chk("t6_sq_e2", 32'(sq), 32'h7);
        step(); chk("t6_tick_e3", 32'(tick), 32'h0);
        step(); chk("t6_tick_e4", 32'(tick), 32'h7); chk("t6_sq_e4", 32'(sq), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
